// File: rtl/bch_encode_stream.sv
// Streaming systematic BCH encoder with valid/ready on both sides, run-time shortening and a parity-only mode.
// P packs the code as {m[7:0], t[7:0], data_bits[15:0]}; the generator polynomial is derived at elaboration.
module bch_encode_stream #(
    parameter logic [31:0] P    = 32'h0402_0007,
    parameter int          BITS = 1,
    parameter int          LW   = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] data_in,
    input  logic [LW-1:0]   len_words,
    input  logic            parity_only,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] data_out,
    output logic            first,
    output logic            last,
    output logic            busy
);

    localparam int M         = int'(P[31:24]);
    localparam int T         = int'(P[23:16]);
    localparam int DATA_BITS = int'(P[15:0]);
    localparam int N         = (1 << M) - 1;
    localparam int MAXE      = M * T;

    function automatic int prim_poly(input int m);
        case (m)
            2:       return 32'h0000_0007;
            3:       return 32'h0000_000B;
            4:       return 32'h0000_0013;
            5:       return 32'h0000_0025;
            6:       return 32'h0000_0043;
            7:       return 32'h0000_0089;
            8:       return 32'h0000_011D;
            9:       return 32'h0000_0211;
            10:      return 32'h0000_0409;
            11:      return 32'h0000_0805;
            12:      return 32'h0000_1053;
            13:      return 32'h0000_201B;
            14:      return 32'h0000_4443;
            15:      return 32'h0000_8003;
            16:      return 32'h0001_002D;
            default: return 32'h0000_0000;
        endcase
    endfunction

    localparam int PRIM = prim_poly(M);

    function automatic int gf_mul(input int a, input int b);
        int r;
        int aa;
        r  = 0;
        aa = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa << 1;
            if (aa[M]) aa = aa ^ PRIM;
        end
        return r;
    endfunction

    // Product of (x + alpha^j) over the union of cyclotomic cosets of 1..2t equals the LCM of the minimal polynomials.
    function automatic logic [MAXE:0] gen_poly();
        int            gc [0:MAXE];
        int            x;
        int            root;
        logic          seen;
        logic          done;
        logic [MAXE:0] res;
        for (int k = 0; k <= MAXE; k++) gc[k] = 0;
        gc[0] = 1;
        for (int i = 1; i <= 2 * T; i++) begin
            seen = 1'b0;
            for (int j = 1; j < i; j++) begin
                x = j;
                for (int s = 0; s < M; s++) begin
                    if (x == i) seen = 1'b1;
                    x = (x * 2) % N;
                end
            end
            if (!seen) begin
                x    = i % N;
                done = 1'b0;
                for (int s = 0; s < M; s++) begin
                    if (!done) begin
                        root = 1;
                        for (int e = 0; e < x; e++) root = gf_mul(root, 2);
                        for (int k = MAXE; k > 0; k--) gc[k] = gc[k-1] ^ gf_mul(root, gc[k]);
                        gc[0] = gf_mul(root, gc[0]);
                        x = (x * 2) % N;
                        if (x == i % N) done = 1'b1;
                    end
                end
            end
        end
        for (int k = 0; k <= MAXE; k++) res[k] = gc[k][0];
        return res;
    endfunction

    function automatic int poly_deg(input logic [MAXE:0] g);
        int d;
        d = 0;
        for (int k = 0; k <= MAXE; k++) begin
            if (g[k]) d = k;
        end
        return d;
    endfunction

    localparam logic [MAXE:0] GPOLY = gen_poly();
    localparam int            ECC   = poly_deg(GPOLY);
    localparam logic [ECC-1:0] GLOW = GPOLY[ECC-1:0];
    localparam int            DW    = DATA_BITS / BITS;
    localparam int            EW    = (ECC + BITS - 1) / BITS;
    localparam int            RUNT  = ((ECC - 1) % BITS) + 1;

    generate
        if (DATA_BITS % BITS != 0) begin : g_err_div
            $error("bch_encode_stream: data bits not a multiple of BITS");
        end
        if (BITS > ECC) begin : g_err_bits
            $error("bch_encode_stream: BITS exceeds parity bit count");
        end
        if (longint'(DW) > ((64'd1 << LW) - 64'd1)) begin : g_err_lw
            $error("bch_encode_stream: LW too narrow for the data word count");
        end
    endgenerate

    // Bit 0 of the word enters the divider first (highest remaining degree).
    function automatic logic [ECC-1:0] lfsr_word(input logic [ECC-1:0] s, input logic [BITS-1:0] w);
        logic [ECC-1:0] r;
        logic           fb;
        r = s;
        for (int i = 0; i < BITS; i++) begin
            fb = w[i] ^ r[ECC-1];
            r  = {r[ECC-2:0], 1'b0} ^ (fb ? GLOW : {ECC{1'b0}});
        end
        return r;
    endfunction

    function automatic logic [BITS-1:0] par_word(input logic [ECC-1:0] s, input logic fin);
        logic [BITS-1:0] o;
        for (int k = 0; k < BITS; k++) begin
            if (fin && (k >= RUNT)) o[k] = 1'b0;
            else                    o[k] = s[ECC-1-k];
        end
        return o;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    localparam logic [LW:0] CNT_ONE = {{LW{1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_state_nx;
    logic [ECC-1:0]  r_lfsr;
    logic [LW:0]     r_cnt;
    logic [LW-1:0]   r_len;
    logic            r_mode;
    logic            r_out_valid;
    logic [BITS-1:0] r_out_data;
    logic            r_first;
    logic            r_last;
    logic            w_slot_free;
    logic            w_in_ready;
    logic            w_accept;
    logic [LW-1:0]   w_len_eff;
    logic [LW:0]     w_cnt_inc;
    logic            w_data_last;
    logic            w_par_first;
    logic            w_par_last;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_len_eff   = ((len_words == {LW{1'b0}}) || (len_words > LW'(DW))) ? LW'(DW) : len_words;
    assign w_cnt_inc   = r_cnt + CNT_ONE;
    assign w_data_last = (w_cnt_inc == {1'b0, r_len});
    assign w_par_first = (r_cnt == {1'b0, r_len});
    assign w_par_last  = (r_cnt == ({1'b0, r_len} + (LW+1)'(EW - 1)));

    // Next-state and input handshake.
    always_comb begin
        w_state_nx = r_state;
        w_in_ready = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = w_slot_free;
                w_accept   = in_valid && w_in_ready;
                if (w_accept) begin
                    if (w_len_eff > LW'(1)) w_state_nx = S_DATA;
                    else                    w_state_nx = S_PARITY;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_DATA: begin
                w_in_ready = r_mode ? 1'b1 : w_slot_free;
                w_accept   = in_valid && w_in_ready;
                if (w_accept && w_data_last) w_state_nx = S_PARITY;
                else                         w_state_nx = S_DATA;
            end
            S_PARITY: begin
                if (w_slot_free && w_par_last) w_state_nx = S_IDLE;
                else                           w_state_nx = S_PARITY;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    // Divider, counters and the single output stage; a consumed slot empties unless refilled this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr      <= {ECC{1'b0}};
            r_cnt       <= {(LW+1){1'b0}};
            r_len       <= {LW{1'b0}};
            r_mode      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= {BITS{1'b0}};
            r_first     <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            if (w_slot_free) begin
                r_out_valid <= 1'b0;
                r_first     <= 1'b0;
                r_last      <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_len  <= w_len_eff;
                        r_mode <= parity_only;
                        r_lfsr <= lfsr_word({ECC{1'b0}}, data_in);
                        r_cnt  <= CNT_ONE;
                        if (!parity_only) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= data_in;
                            r_first     <= 1'b1;
                            r_last      <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_lfsr <= lfsr_word(r_lfsr, data_in);
                        r_cnt  <= w_cnt_inc;
                        if (!r_mode) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= data_in;
                            r_first     <= 1'b0;
                            r_last      <= 1'b0;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_slot_free) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= par_word(r_lfsr, w_par_last);
                        r_first     <= r_mode && w_par_first;
                        r_last      <= w_par_last;
                        r_lfsr      <= r_lfsr << BITS;
                        r_cnt       <= w_cnt_inc;
                    end
                end
                default: begin
                    r_cnt <= {(LW+1){1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_out_data;
    assign first     = r_first;
    assign last      = r_last;
    assign busy      = (r_state != S_IDLE) || r_out_valid;

endmodule

// File: tb/tb_bch_encode_stream.sv
// Randomized bench for bch_encode_stream (m=4, t=2, 7 data bits, BITS=1) against a long-division parity model.
module tb_bch_encode_stream;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [0:0]  data_in;
    logic [15:0] len_words;
    logic        parity_only;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  data_out;
    logic        first;
    logic        last;
    logic        busy;

    always #5 clk = ~clk;

    bch_encode_stream #(.P(32'h0402_0007), .BITS(1), .LW(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .len_words(len_words), .parity_only(parity_only),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .first(first), .last(last), .busy(busy)
    );

    int         n_total = 0;
    int         n_pass  = 0;
    logic [2:0] exp_q[$];
    logic [2:0] e;
    bit         rand_rdy = 1'b0;
    int         rdy_low = 0, b2b_hits = 0, out_words = 0, cyc = 0, acc_cyc = 0, lat = -1;
    bit         lat_armed = 1'b0, fo_armed = 1'b0, prev_stall = 1'b0;
    logic       prev_d, prev_f, prev_l;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Remainder of x^8*d(x) by g(x)=x^8+x^7+x^6+x^4+1; bits[0] is the highest-degree message bit.
    function automatic logic [7:0] model_parity(input logic [63:0] bits, input int k);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < k; i++) v = (v << 1) | {63'd0, bits[i]};
        v = v << 8;
        for (int i = k + 7; i >= 8; i--) begin
            if (v[i]) v = v ^ (64'h1D1 << (i - 8));
        end
        return v[7:0];
    endfunction

    task automatic push_expected(input logic [63:0] bits, input int k, input bit mode);
        logic [7:0] p;
        for (int i = 0; i < k; i++) begin
            if (!mode) exp_q.push_back({bits[i], (i == 0), 1'b0});
        end
        p = model_parity(bits, k);
        for (int j = 0; j < 8; j++) exp_q.push_back({p[7-j], (j == 0) && mode, (j == 7)});
    endtask

    task automatic send_word(input logic d, input logic [15:0] len, input logic po);
        int n;
        n = 0;
        in_valid = 1'b1; data_in = d; len_words = len; parity_only = po;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) chk("send_timeout", n, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_cw(input int lf, input bit mode, input logic [63:0] bits);
        int k;
        k = (lf == 0 || lf > 7) ? 7 : lf;
        push_expected(bits, k, mode);
        for (int i = 0; i < k; i++) send_word(bits[i], lf[15:0], mode);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", (n < 3000), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard compare, stall stability and handshake bookkeeping.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold", {out_valid, data_out, first, last}, {1'b1, prev_d, prev_f, prev_l});
            end
            if (out_valid && out_ready) begin
                out_words++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {data_out, first, last}, 3'b000);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_word", {data_out, first, last}, e);
                end
                if (last && in_valid && in_ready) b2b_hits++;
            end
            if (fo_armed && out_valid && first) begin
                lat = cyc - acc_cyc;
                fo_armed = 1'b0;
            end
            if (lat_armed && in_valid && in_ready) begin
                acc_cyc = cyc;
                lat_armed = 1'b0;
                fo_armed = 1'b1;
            end
            if (!in_ready) rdy_low++;
            prev_stall = out_valid && !out_ready;
            prev_d = data_out; prev_f = first; prev_l = last;
        end
        cyc++;
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; data_in = 1'b0; len_words = 16'd0; parity_only = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", {first, last, data_out}, 3'b000);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("model_pin_x14", model_parity(64'h1, 7), 8'hE8);
        chk("model_pin_x8", model_parity(64'h1, 1), 8'hD1);
        chk("model_pin_zero", model_parity(64'h0, 7), 8'h00);
        @(posedge clk);
        #1;

        rdy_low = 0; out_words = 0; lat_armed = 1'b1;
        send_cw(7, 1'b0, 64'h0);
        drain();
        chk("zero_in_ready_low", rdy_low, 8);
        chk("zero_latency", lat, 1);
        chk("zero_words", out_words, 15);

        out_words = 0;
        send_cw(7, 1'b0, 64'h1);
        drain();
        chk("x6_words", out_words, 15);

        out_words = 0;
        send_cw(1, 1'b0, 64'h1);
        drain();
        chk("len1_words", out_words, 9);

        rdy_low = 0; out_words = 0;
        send_cw(7, 1'b1, 64'h1);
        chk("po_in_ready", rdy_low, 0);
        drain();
        chk("po_words", out_words, 8);

        rand_rdy = 1'b1;
        for (int c = 0; c < 200; c++) begin
            send_cw($urandom_range(0, 9), 1'($urandom_range(0, 1)), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        drain();
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send_cw(7, 1'b1, {$urandom, $urandom});
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        out_words = 0;
        send_cw(7, 1'b0, 64'h1);
        drain();
        chk("post_rst_words", out_words, 15);

        b2b_hits = 0;
        for (int c = 0; c < 4; c++) send_cw(7, 1'b0, {$urandom, $urandom});
        drain();
        chk("b2b_hits", b2b_hits, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
